ahb_lite_master: RTL

AHB-Lite initiator that converts single commands from a local request port into AHB-Lite SINGLE or INCR4 transfers. It drives the bus toward the slaves, including the default slave, and handles wait states and the two-cycle ERROR response. It returns read data and completion or error status to the local side. It is the bus-side counterpart of the team's slave and default-slave models, and acts as the reference initiator in the AHB-Lite environment.

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_lite_master.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state type used by the bus models.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } mst_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one local command into a SINGLE or INCR4 transfer,
// overlapping address and data phases, honouring wait states and ERROR responses.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic                  cmd_incr4,
    output logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    mst_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [1:0]            r_addr_cnt;
    logic [1:0]            r_data_cnt;
    logic [1:0]            r_last;
    logic                  r_dphase;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_done;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_addr_step;
    logic                  w_err_first;

    assign w_addr_step = ADDR_WIDTH'(1) << r_hsize;
    // First ERROR cycle: only meaningful while a data phase is actually outstanding.
    assign w_err_first = r_dphase && !HREADY && (HRESP == HRESP_ERROR);

    // NOTE: wr_req is combinational on HREADY so the caller presents data on the very edge it is loaded.
    assign wr_req    = (r_state == ST_ADDR) && r_hwrite && HREADY;
    assign cmd_ready = (r_state == ST_IDLE);

    assign HADDR    = r_haddr;
    assign HTRANS   = r_htrans;
    assign HWRITE   = r_hwrite;
    assign HSIZE    = r_hsize;
    assign HBURST   = r_hburst;
    assign HWDATA   = r_hwdata;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign done     = r_done;
    assign err      = r_err;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_haddr    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b000;
            r_hburst   <= HBURST_SINGLE;
            r_hwdata   <= '0;
            r_addr_cnt <= 2'd0;
            r_data_cnt <= 2'd0;
            r_last     <= 2'd0;
            r_dphase   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_haddr    <= cmd_addr;
                        r_htrans   <= HTRANS_NONSEQ;
                        r_hwrite   <= cmd_write;
                        r_hsize    <= cmd_size;
                        r_hburst   <= cmd_incr4 ? HBURST_INCR4 : HBURST_SINGLE;
                        r_last     <= cmd_incr4 ? 2'd3 : 2'd0;
                        r_addr_cnt <= 2'd0;
                        r_data_cnt <= 2'd0;
                        r_dphase   <= 1'b0;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_err_first) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= ST_ERR;
                    end else if (HREADY) begin
                        if (r_hwrite) r_hwdata <= wr_data;
                        if (r_dphase) begin
                            if (!r_hwrite) begin
                                r_rd_data  <= HRDATA;
                                r_rd_valid <= 1'b1;
                            end
                            r_data_cnt <= r_data_cnt + 2'd1;
                        end
                        r_dphase <= 1'b1;
                        if (r_addr_cnt == r_last) begin
                            r_htrans <= HTRANS_IDLE;
                            r_state  <= ST_DATA;
                        end else begin
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            r_haddr    <= r_haddr + w_addr_step;
                            r_htrans   <= HTRANS_SEQ;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_err_first) begin
                        r_state <= ST_ERR;
                    end else if (HREADY && r_data_cnt == r_last) begin
                        if (!r_hwrite) begin
                            r_rd_data  <= HRDATA;
                            r_rd_valid <= 1'b1;
                        end
                        r_dphase <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (HREADY && HRESP == HRESP_ERROR) begin
                        r_dphase <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
